// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its multiplier sequencer.
// Holds the alu32 operation select codes and the sequencer state encoding.
package alu_pkg;

  // alu32 operation select codes (S input)
  localparam logic [2:0] ALU_XOR  = 3'b000;
  localparam logic [2:0] ALU_XNOR = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;

  // Multiplier sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the shared alu32 for one
// add per clock over 32 iterations, producing a 64-bit product.
// Optional macro MUL_SIGNED_EN adds an is_signed input for two's-complement
// multiplication (sign-correct shift-in and a final subtract step).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef MUL_SIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_S,
  output logic                 alu_Cin,
  input  logic [WIDTH-1:0]     alu_d,
  input  logic                 alu_Cout,
  input  logic                 alu_V
);

  mul_state_t           r_state;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_p;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_last;
  logic                 w_sh;
  logic [2*WIDTH-1:0]   w_p_next;

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

`ifdef MUL_SIGNED_EN
  logic                 r_signed;

  // Signed mode shifts in the true sign of the sum; unsigned keeps the carry
  assign w_sh = r_signed ? (alu_d[WIDTH-1] ^ alu_V) : alu_Cout;
`else
  logic                 w_unused_v;

  assign w_unused_v = alu_V;
  assign w_sh       = alu_Cout;
`endif

  // Partial sum from alu32 lands in the high half while the multiplier
  // bits shift out of the low half.
  assign w_p_next = {w_sh, alu_d, r_p[WIDTH-1:1]};

  // Drive alu32 only while iterating; otherwise present a harmless ADD of zeros
  always_comb begin
    alu_S   = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    alu_Cin = 1'b0;
    if (r_state == ST_RUN) begin
      alu_a = r_p[2*WIDTH-1:WIDTH];
      alu_b = r_p[0] ? r_mcand : '0;
`ifdef MUL_SIGNED_EN
      // Multiplier sign bit carries weight -2^31, so subtract on the last step
      if (r_signed && w_last && r_p[0]) begin
        alu_S   = ALU_SUB;
        alu_b   = r_mcand;
        alu_Cin = 1'b1;
      end
`endif
    end
  end

  // Control FSM with registered handshake outputs and datapath updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_mcand   <= '0;
      r_p       <= '0;
      r_product <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MUL_SIGNED_EN
      r_signed  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= mcand;
            r_p     <= {{WIDTH{1'b0}}, mplier};
            r_count <= '0;
`ifdef MUL_SIGNED_EN
            r_signed <= is_signed;
`endif
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_p     <= w_p_next;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_product <= w_p_next;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural alu32 beside it.
// Expected products come from plain 64-bit multiplication.
// Define MUL_SIGNED_EN to also exercise the signed mode.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_S;
  logic        alu_Cin;
  logic [31:0] alu_d;
  logic        alu_Cout;
  logic        alu_V;

  int checks;
  int failures;

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef MUL_SIGNED_EN
    .is_signed(is_signed),
`endif
    .mcand    (mcand),
    .mplier   (mplier),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_S    (alu_S),
    .alu_Cin  (alu_Cin),
    .alu_d    (alu_d),
    .alu_Cout (alu_Cout),
    .alu_V    (alu_V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu32
  always_comb begin
    logic [32:0] s;
    s        = '0;
    alu_d    = '0;
    alu_Cout = 1'b0;
    alu_V    = 1'b0;
    case (alu_S)
      3'b010: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_Cin};
        alu_d    = s[31:0];
        alu_Cout = s[32];
        alu_V    = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      3'b011: begin
        s        = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'b0, alu_Cin};
        alu_d    = s[31:0];
        alu_Cout = s[32];
        alu_V    = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
      end
      3'b000:  alu_d = alu_a ^ alu_b;
      3'b001:  alu_d = ~(alu_a ^ alu_b);
      3'b100:  alu_d = alu_a | alu_b;
      3'b101:  alu_d = ~(alu_a | alu_b);
      3'b110:  alu_d = alu_a & alu_b;
      default: alu_d = '0;
    endcase
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, latency, product, done width, return to idle
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn);
    int n;
    logic [63:0] exp;
    exp = ref_mul(a, b, sgn);
    @(negedge clk);
    mcand = a; mplier = b; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mcand = $urandom; mplier = $urandom; is_signed = ~sgn;
    check({tag, "_ready_low"}, {63'b0, ready}, 64'd0);
    check({tag, "_busy_high"}, {63'b0, busy}, 64'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {63'b0, done}, 64'd0);
    check({tag, "_ready_back"}, {63'b0, ready}, 64'd1);
  endtask

  initial begin
    int n, pulses;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_alu_S", {61'b0, alu_S}, 64'd2);
    @(negedge clk); rst_n = 1'b1;

    run_op("u3x5", 32'd3, 32'd5, 1'b0);
    check("u3x5_const", product, 64'h0000_0000_0000_000F);
    run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("uffxff_const", product, 64'hFFFF_FFFE_0000_0001);
    run_op("u8x2", 32'h8000_0000, 32'd2, 1'b0);
    check("u8x2_const", product, 64'h0000_0001_0000_0000);
    run_op("u0x", 32'd0, 32'h1234_5678, 1'b0);
    check("u0x_const", product, 64'd0);

    for (int i = 0; i < 6; i++) run_op("urand", $urandom, $urandom, 1'b0);

    // Start held through RUN and DONE: exactly one operation
    @(negedge clk);
    mcand = 32'h1234; mplier = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    mcand = 32'hDEAD_BEEF; mplier = 32'h0BAD_F00D;
    n = 0; pulses = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (done) pulses++;
    check("hold_latency", 64'(n), 64'd32);
    check("hold_product", product, 64'h0001_2340);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_idle_busy", {63'b0, busy}, 64'd0);
    run_op("after_hold", 32'd9, 32'd11, 1'b0);

    // Asynchronous reset during iteration 10
    @(negedge clk);
    mcand = 32'h0001_0001; mplier = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {63'b0, ready}, 64'd1);
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    run_op("u7x6", 32'd7, 32'd6, 1'b0);
    check("u7x6_const", product, 64'h2A);

`ifdef MUL_SIGNED_EN
    run_op("sffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("sffxff_const", product, 64'h1);
    run_op("sffx2", 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("sffx2_const", product, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("s8x8", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("s8x8_const", product, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 6; i++) run_op("srand", $urandom, $urandom, 1'b1);
    run_op("uffxff_sbuild", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
